// File: rtl/seq_mag_comp.sv
// ---------------------------------------------------------------------------
// seq_mag_comp
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are latched on an
// accepted start and compared CHUNK bits per cycle, MSB chunk first. The scan
// stops on the first chunk that differs, or after the last chunk when the
// operands are equal. The result is registered on e/g/l and held until the
// next request reaches its own DONE cycle.
//
// Build option:
//   SEQ_MAG_COMP_SIGNED_EN  when defined, operands are two's-complement. The
//                           top bit of chunk 0 is inverted on both operands
//                           so that the sign bit orders correctly. All other
//                           chunks stay unsigned.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset, aborts any compare in flight
//   start  in   request, only sampled while idle
//   a, b   in   operands, captured on an accepted start
//   busy   out  high while a request is in progress (CMP or DONE)
//   done   out  one-cycle pulse, e/g/l are valid for this request
//   e/g/l  out  a == b / a > b / a < b
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               e_reg, e_next;
    logic               g_reg, g_next;
    logic               l_reg, l_next;

    // Latched operands split into chunks; index 0 is the most significant.
    logic [CHUNK-1:0]   a_chunk [NCHUNK];
    logic [CHUNK-1:0]   b_chunk [NCHUNK];
    logic [CHUNK-1:0]   a_cur;
    logic [CHUNK-1:0]   b_cur;
    logic               last_chunk;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            localparam int HI = WIDTH - 1 - gi * CHUNK;
`ifdef SEQ_MAG_COMP_SIGNED_EN
            if (gi == 0) begin : g_sign
                // Flipping the sign bit maps two's-complement order onto
                // unsigned order for the top chunk.
                localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);
                assign a_chunk[gi] = a_reg[HI -: CHUNK] ^ SIGN_MASK;
                assign b_chunk[gi] = b_reg[HI -: CHUNK] ^ SIGN_MASK;
            end else begin : g_plain
                assign a_chunk[gi] = a_reg[HI -: CHUNK];
                assign b_chunk[gi] = b_reg[HI -: CHUNK];
            end
`else
            assign a_chunk[gi] = a_reg[HI -: CHUNK];
            assign b_chunk[gi] = b_reg[HI -: CHUNK];
`endif
        end
    endgenerate

    assign a_cur      = a_chunk[idx_reg];
    assign b_cur      = b_chunk[idx_reg];
    assign last_chunk = (idx_reg == IDX_W'(NCHUNK - 1));

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        e_next     = e_reg;
        g_next     = g_reg;
        l_next     = l_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    idx_next   = '0;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (a_cur != b_cur) begin
                    e_next     = 1'b0;
                    g_next     = (a_cur > b_cur);
                    l_next     = (a_cur < b_cur);
                    state_next = DONE;
                end else if (last_chunk) begin
                    e_next     = 1'b1;
                    g_next     = 1'b0;
                    l_next     = 1'b0;
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // busy/done are registered copies of the next-state decode so the
        // outputs come from flops rather than from state decode logic.
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            e_reg     <= 1'b0;
            g_reg     <= 1'b0;
            l_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            e_reg     <= e_next;
            g_reg     <= g_next;
            l_reg     <= l_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign e    = e_reg;
    assign g    = g_reg;
    assign l    = l_reg;

endmodule

// File: tb/tb_seq_mag_comp.sv
// ---------------------------------------------------------------------------
// tb_seq_mag_comp
//
// Bench for seq_mag_comp with two instances: the default 16/4 configuration
// and a 4/4 (single chunk) configuration. Requests push their expected
// result and chunk count into a queue; per-instance monitors pop and compare
// whenever done pulses. Expected values follow SEQ_MAG_COMP_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_seq_mag_comp;

    localparam logic [2:0] EQ = 3'b100;  // {e,g,l}
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct {
        logic [2:0] res;
        int         k;
        int         t;
    } exp_t;

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        int          k;
        logic [2:0]  ru;
        logic [2:0]  rs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, e, g, l;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        busy1, done1, e1, g1, l1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    exp_t q16[$];
    exp_t q4[$];
    exp_t m16;
    exp_t m4;

    vec_t vecs [7] = '{
        '{16'h1234, 16'h1234, 4, EQ, EQ},
        '{16'h8000, 16'h7FFF, 1, GT, LT},
        '{16'h1235, 16'h1234, 4, GT, GT},
        '{16'hFFFF, 16'hFFFE, 4, GT, GT},
        '{16'h0100, 16'h0200, 2, LT, LT},
        '{16'h00A0, 16'h0090, 3, GT, GT},
        '{16'h7FFF, 16'h8000, 1, LT, GT}
    };

    seq_mag_comp #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .e(e), .g(g), .l(l)
    );

    seq_mag_comp #(.WIDTH(4), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .e(e1), .g(g1), .l(l1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] pick(input logic [2:0] ru, input logic [2:0] rs);
`ifdef SEQ_MAG_COMP_SIGNED_EN
        return rs;
`else
        return ru;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Scoreboard monitors: one line per completed transaction.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q16.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done16: got done=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                m16 = q16.pop_front();
                chk("res16_egl", {29'd0, e, g, l}, {29'd0, m16.res});
                chk("lat16", cyc - m16.t, m16.k);
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q4.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done4: got done=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                m4 = q4.pop_front();
                chk("res4_egl", {29'd0, e1, g1, l1}, {29'd0, m4.res});
                chk("lat4", cyc - m4.t, m4.k);
            end
        end
    end

    // Issue one request on the 16-bit instance; operands are scrambled
    // right after acceptance since only the latched copies should matter.
    task automatic req16(input logic [15:0] av, input logic [15:0] bv,
                         input int k, input logic [2:0] r);
        exp_t x;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        x.res = r; x.k = k; x.t = cyc;
        q16.push_back(x);
    endtask

    task automatic req4(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] r);
        exp_t x;
        @(negedge clk);
        a1 = av; b1 = bv; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1 = ~av;
        b1 = ~bv;
        x.res = r; x.k = 1; x.t = cyc;
        q4.push_back(x);
    endtask

    task automatic wait_idle16();
        int n = 0;
        while ((q16.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 40) begin
            mismatched++;
            $display("FAIL wait16: got still busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic wait_idle4();
        int n = 0;
        while ((q4.size() != 0 || busy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 20) begin
            mismatched++;
            $display("FAIL wait4: got still busy after %0d cycles expected idle", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [3:0] x4, y4;
        logic [2:0] r4;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_egl", {29'd0, e, g, l}, 0);
        chk("reset_busy4", busy1, 0);
        rst = 1'b0;

        // Directed vectors.
        foreach (vecs[i]) begin
            req16(vecs[i].av, vecs[i].bv, vecs[i].k, pick(vecs[i].ru, vecs[i].rs));
            wait_idle16();
        end

        // Busy-ignore: re-pulse start during CMP and during DONE.
        req16(16'h0001, 16'h0002, 4, LT);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("saw_done_busy_test", done, 1);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle16();
        @(negedge clk);
        chk("ignored_start_idle", busy, 0);
        req16(16'hFFFF, 16'h0000, 1, pick(GT, LT));
        wait_idle16();

        // Hold: previous g result stays visible while the next request scans.
        req16(16'h1235, 16'h1234, 4, GT);
        wait_idle16();
        req16(16'h0005, 16'h0005, 4, EQ);
        repeat (4) begin
            @(negedge clk);
            chk("hold_g", g, 1);
            chk("hold_e", e, 0);
            chk("hold_nodone", done, 0);
        end
        wait_idle16();

        // Mid-operation reset at the 2nd CMP cycle: no done, outputs clear.
        req16(16'h0005, 16'h0005, 4, EQ);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(q16.pop_back());
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_egl", {29'd0, e, g, l}, 0);
        repeat (8) @(negedge clk);
        chk("midrst_still_idle", busy, 0);

        // Single-chunk instance, exhaustive.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                x4 = 4'(ai);
                y4 = 4'(bi);
`ifdef SEQ_MAG_COMP_SIGNED_EN
                r4 = (x4 == y4) ? EQ : (($signed(x4) > $signed(y4)) ? GT : LT);
`else
                r4 = (x4 == y4) ? EQ : ((x4 > y4) ? GT : LT);
`endif
                req4(x4, y4, r4);
                wait_idle4();
            end
        end

        repeat (3) @(negedge clk);
        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
